// File: rtl/ram_loader.sv
// ram_loader: streams 16 bytes over valid/ready into consecutive
// memory addresses through the 16-line demux, one write strobe per byte.
module ram_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] load_data,
    output logic [ADDR_W-1:0] load_addr,
    output logic              load_we,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    state_t state;
    state_t state_nx;

    logic accept;
    logic at_last;

    assign accept  = in_valid && (state == FETCH);
    assign at_last = (load_addr == LAST);

    // State register; clr returns to IDLE from anywhere.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state: abort wins over start and the handshake.
    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) state_nx = FETCH;
                end
                FETCH: begin
                    if (accept) state_nx = WRITE;
                end
                WRITE: begin
                    state_nx = at_last ? DONE : FETCH;
                end
                DONE: begin
                    if (start) state_nx = FETCH;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    // Address counter and byte latch; both hold on abort.
    always_ff @(posedge clk) begin
        if (clr) begin
            load_addr <= '0;
            load_data <= '0;
        end else if (!abort) begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) load_addr <= '0;
                end
                FETCH: begin
                    if (accept) load_data <= in_data;
                end
                WRITE: begin
                    if (!at_last) load_addr <= load_addr + ADDR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs are pure decodes of the state register.
    always_comb begin
        in_ready = 1'b0;
        load_we  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE:  ;
            FETCH: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            WRITE: begin
                load_we = 1'b1;
                busy    = 1'b1;
            end
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed sequence with random bytes and gaps; a byte
// list reference predicts every write as (address k, k-th accepted byte).
module tb_ram_loader;

    logic       clk = 1'b0;
    logic       clr;
    logic       start;
    logic       abort;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] load_data;
    logic [3:0] load_addr;
    logic       load_we;
    logic       busy;
    logic       done;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int s;

    logic [7:0]  bq[16];
    logic [11:0] wq[$];
    int          wcyc[$];

    ram_loader #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .clr(clr), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .load_data(load_data), .load_addr(load_addr),
        .load_we(load_we), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Edge counter used to time strobes and done.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe seen by the memory.
    always @(negedge clk) begin
        if (load_we === 1'b1) begin
            wq.push_back({load_addr, load_data});
            wcyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic rand_bytes();
        for (int k = 0; k < 16; k++) bq[k] = 8'($urandom);
    endtask

    task automatic idle_outs(input string tag);
        chk({tag, "_ready"}, 32'(in_ready), 0);
        chk({tag, "_we"}, 32'(load_we), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // Offer bytes bq[first..first+n-1]; returns in the WRITE cycle of the last.
    task automatic feed(input int first, input int n, input bit gaps);
        int  i;
        int  budget;
        bit  acc;
        bit  hold;
        logic [3:0] a0;
        i = 0;
        budget = 0;
        while (i < n && budget < 400) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = in_valid ? bq[first+i] : 8'($urandom);
            acc  = in_valid && in_ready;
            hold = in_ready && !in_valid;
            a0   = load_addr;
            tick();
            budget++;
            if (acc) i++;
            if (hold) chk("gap_hold", 32'({load_addr, in_ready}), 32'({a0, 1'b1}));
        end
        in_valid = 1'b0;
        if (i < n) chk("feed_timeout", 32'(i), 32'(n));
    endtask

    task automatic check_writes(input int n);
        chk("wr_count", 32'(wq.size()), 32'(n));
        for (int k = 0; k < n && k < wq.size(); k++)
            chk("wr_entry", 32'(wq[k]), 32'({k[3:0], bq[k]}));
    endtask

    initial begin
        clr      = 1'b1;
        start    = 1'b1;
        abort    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h5A;

        // Reset with start and valid asserted.
        tick();
        tick();
        idle_outs("rst");
        chk("rst_addr", 32'(load_addr), 0);
        chk("rst_data", 32'(load_data), 0);
        clr      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        idle_outs("post_rst");

        // Full load, valid held high, bytes 0x10..0x1F.
        for (int k = 0; k < 16; k++) bq[k] = 8'(8'h10 + k);
        wq.delete();
        wcyc.delete();
        do_start();
        s = cyc;
        chk("start_ready", 32'(in_ready), 1);
        chk("start_addr", 32'(load_addr), 0);
        feed(0, 16, 1'b0);
        chk("last_we", 32'(load_we), 1);
        chk("last_addr", 32'(load_addr), 15);
        chk("done_early", 32'(done), 0);
        tick();
        chk("done_rise", 32'(done), 1);
        chk("busy_fall", 32'(busy), 0);
        chk("done_cycle", 32'(cyc - s), 32);
        check_writes(16);
        for (int k = 0; k < 16 && k < wcyc.size(); k++)
            chk("wr_spacing", 32'(wcyc[k] - s), 32'(1 + 2 * k));
        tick();
        chk("done_sticky", 32'(done), 1);

        // Reload from DONE with 0xA0..0xAF.
        for (int k = 0; k < 16; k++) bq[k] = 8'(8'hA0 + k);
        wq.delete();
        do_start();
        chk("reload_done_clr", 32'(done), 0);
        chk("reload_ready", 32'(in_ready), 1);
        chk("reload_addr", 32'(load_addr), 0);
        feed(0, 16, 1'b0);
        tick();
        chk("reload_done", 32'(done), 1);
        check_writes(16);

        // Random bytes with random gaps.
        rand_bytes();
        wq.delete();
        do_start();
        feed(0, 16, 1'b1);
        tick();
        chk("gap_done", 32'(done), 1);
        check_writes(16);

        // Abort in FETCH at address 5.
        rand_bytes();
        wq.delete();
        do_start();
        feed(0, 5, 1'b0);
        tick();
        chk("abort_pre_addr", 32'(load_addr), 5);
        chk("abort_pre_ready", 32'(in_ready), 1);
        abort    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hEE;
        tick();
        abort    = 1'b0;
        in_valid = 1'b0;
        idle_outs("abort");
        tick();
        tick();
        tick();
        idle_outs("abort_stay");
        check_writes(5);

        // New start after abort rewrites from address 0.
        rand_bytes();
        wq.delete();
        do_start();
        chk("restart_addr", 32'(load_addr), 0);
        feed(0, 16, 1'b1);
        tick();
        chk("restart_done", 32'(done), 1);
        check_writes(16);

        // Abort from DONE, then start + abort together in IDLE.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        idle_outs("abort_done");
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        idle_outs("start_abort");
        tick();
        idle_outs("start_abort2");

        // Start during FETCH ignored, then clr during WRITE at 9.
        rand_bytes();
        wq.delete();
        do_start();
        feed(0, 3, 1'b1);
        tick();
        chk("fetch_addr", 32'(load_addr), 3);
        start    = 1'b1;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        chk("ign_start_addr", 32'(load_addr), 3);
        chk("ign_start_ready", 32'(in_ready), 1);
        feed(3, 7, 1'b1);
        chk("clr_pre_we", 32'(load_we), 1);
        chk("clr_pre_addr", 32'(load_addr), 9);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        idle_outs("clr_mid");
        chk("clr_addr", 32'(load_addr), 0);
        chk("clr_data", 32'(load_data), 0);
        tick();
        tick();
        tick();
        idle_outs("clr_stay");
        check_writes(10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard stop in case the sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
